tlul_xbar_1ton: RTL and testbench
=================================

TLUL_XBAR_1TON -- requirements
Module: tlul_xbar_1ton

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width.
REQ-003 Parameter MASK_WIDTH, default DATA_WIDTH/8, byte-mask width.
REQ-004 Parameter SIZE_WIDTH, default 3; OPCODE_WIDTH, default 3.
REQ-005 Parameter NUM_SLAVES, default 4, number of slave ports (range 2..16).
REQ-006 Parameter REGION_LSB, default 12, lowest address bit of the slave-select field.
REQ-007 Clock and reset: one clock, clk_24; reset rst_n, asynchronous, active-low.
REQ-008 clk_24  in  1  system clock.
REQ-009 rst_n  in  1  async active-low reset.
REQ-010 m_a_valid, m_a_ready  in/out  1  master A handshake.
REQ-011 m_a_opcode, m_a_size, m_a_address, m_a_mask, m_a_data  in  OPCODE/SIZE/ADDR/MASK/DATA_WIDTH  master A payload.
REQ-012 m_d_valid out, m_d_ready in  1  master D handshake.
REQ-013 m_d_opcode, m_d_size, m_d_data, m_d_denied  out  OPCODE/SIZE/DATA_WIDTH/1  master D payload.
REQ-014 s_a_valid out, s_a_ready in  NUM_SLAVES  per-slave A handshake, bit i = slave i.
REQ-015 s_a_opcode, s_a_size, s_a_address, s_a_mask, s_a_data  out  same as master  registered A payload, broadcast to all slaves.
REQ-016 s_d_valid in, s_d_ready out  NUM_SLAVES  per-slave D handshake.
REQ-017 s_d_opcode, s_d_size, s_d_data, s_d_denied  in  NUM_SLAVES x field width, flattened, slave i at [i*W +: W].
REQ-018 busy  out  1  high when state is not IDLE.
REQ-019 err_count  out  8  count of unmapped-address requests.

Function
REQ-020 Decode: slave i selected when m_a_address[ADDR_WIDTH-1:REGION_LSB] == i and i < NUM_SLAVES; otherwise unmapped.
REQ-021 One outstanding transaction; states IDLE, REQ, RESP, ERR.
REQ-022 IDLE: m_a_ready=1; on m_a_valid&&m_a_ready capture payload and select index; next REQ if mapped, ERR if unmapped.
REQ-023 REQ: s_a_valid[sel]=1, all other bits 0, m_a_ready=0; on s_a_ready[sel] go RESP.
REQ-024 RESP: m_d_valid/opcode/size/data/denied combinationally from slave sel; s_d_ready[sel]=m_d_ready; on m_d_valid&&m_d_ready go IDLE.
REQ-025 ERR: m_d_valid=1, m_d_denied=1, m_d_data=0, m_d_size=captured size, m_d_opcode=1 (AccessAckData) if captured opcode=4 (Get), else 0 (AccessAck); on m_d_ready go IDLE.
REQ-026 Latency: s_a_valid or ERR m_d_valid asserts the cycle after the master A handshake; D pass-through adds zero cycles.
REQ-027 s_d_ready of non-selected slaves is 0 in all states; s_d_valid from non-selected slaves is ignored.
REQ-028 s_d_valid[sel] asserted during REQ is not forwarded until RESP.
REQ-029 Payload is held stable on s_a_* from capture until next capture.
REQ-030 err_count increments by 1 on entry to ERR and saturates at 255.

Reset
REQ-031 Asynchronous reset forces IDLE immediately, including mid-REQ/RESP/ERR; the in-flight transaction is dropped.
REQ-032 Reset values: state IDLE, s_a_valid=0, m_d_valid=0, s_d_ready=0, busy=0, err_count=0, captured payload and select=0; m_a_ready=1 after reset release.

Configuration
REQ-033 Macro TLUL_XBAR_ERR_CNT_EN: defined -> err_count counter per REQ-030; undefined -> no counter register, err_count tied to 0, all other behaviour unchanged.

Verification
REQ-034 Get 0x0000_1004 with slave1 ready, slave1 returns opcode 1 data 0xDEAD_BEEF -> s_a_valid=4'b0010 one cycle after handshake; m_d_data=0xDEAD_BEEF, m_d_denied=0.
REQ-035 PutFull 0x0000_3000 data 0x1234_5678 mask 0xF, slave3 s_a_ready delayed 5 cycles -> s_a_valid[3] held 5 cycles, payload stable, m_a_ready=0 throughout.
REQ-036 Get 0x0001_0000 (unmapped) -> next cycle m_d_valid=1, opcode 1, denied 1, data 0; err_count 0->1; no s_a_valid bit asserted.
REQ-037 Slave0 asserts s_d_valid while transaction targets slave2, m_d_ready held 0 for 3 cycles -> m_d_valid=0 until slave2 responds; response held until m_d_ready.
REQ-038 rst_n low during RESP -> s_d_ready, m_d_valid, busy 0 immediately; next Get to slave0 completes normally.
REQ-039 300 unmapped requests with TLUL_XBAR_ERR_CNT_EN -> err_count=255; without macro -> err_count=0.

Source files
------------

// File: rtl/tlul_xbar_1ton.sv
// -----------------------------------------------------------------------------
// tlul_xbar_1ton
//   One-master to NUM_SLAVES-slave TileLink-UL style crossbar with a single
//   outstanding transaction. The master A request is captured in IDLE and
//   decoded on address bits [ADDR_WIDTH-1:REGION_LSB]:
//     - a field value i < NUM_SLAVES selects slave i
//     - any other value is unmapped and gets a denied response from the
//       crossbar itself
//   The captured payload is broadcast on s_a_* and held stable until the
//   next capture. The D channel of the selected slave passes through
//   combinationally to the master.
//
//   States: IDLE -> REQ -> RESP -> IDLE        (mapped)
//           IDLE -> ERR -> IDLE                (unmapped)
//
// Ports
//   clk_24, rst_n          clock, asynchronous active-low reset
//   m_a_*                  master A channel (valid/ready + payload)
//   m_d_*                  master D channel (valid/ready + payload)
//   s_a_valid/s_a_ready    per-slave A handshake, bit i = slave i
//   s_a_*                  registered A payload, shared by all slaves
//   s_d_valid/s_d_ready    per-slave D handshake, bit i = slave i
//   s_d_*                  per-slave D payload, flattened, slave i at [i*W +: W]
//   busy                   high whenever the FSM is not IDLE
//   err_count              saturating count of unmapped requests
//
// Configuration
//   TLUL_XBAR_ERR_CNT_EN   defined: err_count counts ERR entries (saturates
//                          at 255). Undefined: no counter, err_count is 0.
// -----------------------------------------------------------------------------
module tlul_xbar_1ton #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int NUM_SLAVES   = 4,
  parameter int REGION_LSB   = 12
) (
  input  logic                             clk_24,
  input  logic                             rst_n,

  input  logic                             m_a_valid,
  output logic                             m_a_ready,
  input  logic [OPCODE_WIDTH-1:0]          m_a_opcode,
  input  logic [SIZE_WIDTH-1:0]            m_a_size,
  input  logic [ADDR_WIDTH-1:0]            m_a_address,
  input  logic [MASK_WIDTH-1:0]            m_a_mask,
  input  logic [DATA_WIDTH-1:0]            m_a_data,

  output logic                             m_d_valid,
  input  logic                             m_d_ready,
  output logic [OPCODE_WIDTH-1:0]          m_d_opcode,
  output logic [SIZE_WIDTH-1:0]            m_d_size,
  output logic [DATA_WIDTH-1:0]            m_d_data,
  output logic                             m_d_denied,

  output logic [NUM_SLAVES-1:0]            s_a_valid,
  input  logic [NUM_SLAVES-1:0]            s_a_ready,
  output logic [OPCODE_WIDTH-1:0]          s_a_opcode,
  output logic [SIZE_WIDTH-1:0]            s_a_size,
  output logic [ADDR_WIDTH-1:0]            s_a_address,
  output logic [MASK_WIDTH-1:0]            s_a_mask,
  output logic [DATA_WIDTH-1:0]            s_a_data,

  input  logic [NUM_SLAVES-1:0]            s_d_valid,
  output logic [NUM_SLAVES-1:0]            s_d_ready,
  input  logic [NUM_SLAVES*OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [NUM_SLAVES*SIZE_WIDTH-1:0] s_d_size,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_d_data,
  input  logic [NUM_SLAVES-1:0]            s_d_denied,

  output logic                             busy,
  output logic [7:0]                       err_count
);

  localparam int FIELD_W = ADDR_WIDTH - REGION_LSB;
  localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_GET          = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK          = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA     = OPCODE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ERR
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [SIZE_WIDTH-1:0]   size_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic [MASK_WIDTH-1:0]   mask_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic                    dec_hit;
  logic [SEL_W-1:0]        dec_idx;
  logic                    a_fire;

  // Address decode: compare the region field against each slave index so
  // that field values at or above NUM_SLAVES fall out as unmapped.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment;
    // a path that leaves one unassigned would infer a latch.
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (m_a_address[ADDR_WIDTH-1:REGION_LSB] == FIELD_W'(i)) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  // m_a_ready is high exactly in IDLE, so the handshake is valid-in-IDLE.
  assign a_fire = m_a_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk_24 or negedge rst_n) begin
    // NOTE: the captured payload and select are plain flops, so they are
    // reset to zero along with the state; the reset value is visible on s_a_*.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      opcode_q  <= '0;
      size_q    <= '0;
      address_q <= '0;
      mask_q    <= '0;
      data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      state_q <= state_d;
      if (a_fire) begin
        sel_q     <= dec_idx;
        opcode_q  <= m_a_opcode;
        size_q    <= m_a_size;
        address_q <= m_a_address;
        mask_q    <= m_a_mask;
        data_q    <= m_a_data;
      end
    end
  end

  assign s_a_opcode  = opcode_q;
  assign s_a_size    = size_q;
  assign s_a_address = address_q;
  assign s_a_mask    = mask_q;
  assign s_a_data    = data_q;
  assign busy        = (state_q != ST_IDLE);

  // Next state and all handshake / D-channel outputs.
  always_comb begin
    state_d    = state_q;
    m_a_ready  = 1'b0;
    s_a_valid  = '0;
    s_d_ready  = '0;
    m_d_valid  = 1'b0;
    m_d_opcode = '0;
    m_d_size   = '0;
    m_d_data   = '0;
    m_d_denied = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        m_a_ready = 1'b1;
        if (m_a_valid) state_d = dec_hit ? ST_REQ : ST_ERR;
      end

      ST_REQ: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (sel_q == SEL_W'(i)) begin
            s_a_valid[i] = 1'b1;
            if (s_a_ready[i]) state_d = ST_RESP;
          end
        end
      end

      // Only the selected slave's D channel is visible; the others see
      // s_d_ready low and their s_d_valid is ignored.
      ST_RESP: begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (sel_q == SEL_W'(i)) begin
            m_d_valid    = s_d_valid[i];
            m_d_opcode   = s_d_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
            m_d_size     = s_d_size[i*SIZE_WIDTH +: SIZE_WIDTH];
            m_d_data     = s_d_data[i*DATA_WIDTH +: DATA_WIDTH];
            m_d_denied   = s_d_denied[i];
            s_d_ready[i] = m_d_ready;
            if (s_d_valid[i] && m_d_ready) state_d = ST_IDLE;
          end
        end
      end

      // Crossbar-generated denied response; a Get still expects data.
      ST_ERR: begin
        m_d_valid  = 1'b1;
        m_d_denied = 1'b1;
        m_d_size   = size_q;
        m_d_opcode = (opcode_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
        if (m_d_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef TLUL_XBAR_ERR_CNT_EN
  logic [7:0] err_count_q;

  // Counts entries into ERR, i.e. accepted unmapped requests; sticks at 255.
  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else if (a_fire && !dec_hit && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tlul_xbar_1ton.sv
// -----------------------------------------------------------------------------
// tb_tlul_xbar_1ton
//   Directed bench for tlul_xbar_1ton with default parameters. Expected D
//   responses are pushed to a scoreboard queue when a request is issued and
//   popped when the master D handshake is observed. Inputs change on the
//   falling edge; outputs are sampled 1 ns after the falling edge.
// -----------------------------------------------------------------------------
module tb_tlul_xbar_1ton;

  localparam int NS = 4;

`ifdef TLUL_XBAR_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk_24 = 1'b0;
  logic           rst_n;
  logic           m_a_valid;
  logic           m_a_ready;
  logic [2:0]     m_a_opcode;
  logic [2:0]     m_a_size;
  logic [31:0]    m_a_address;
  logic [3:0]     m_a_mask;
  logic [31:0]    m_a_data;
  logic           m_d_valid;
  logic           m_d_ready;
  logic [2:0]     m_d_opcode;
  logic [2:0]     m_d_size;
  logic [31:0]    m_d_data;
  logic           m_d_denied;
  logic [NS-1:0]  s_a_valid;
  logic [NS-1:0]  s_a_ready;
  logic [2:0]     s_a_opcode;
  logic [2:0]     s_a_size;
  logic [31:0]    s_a_address;
  logic [3:0]     s_a_mask;
  logic [31:0]    s_a_data;
  logic [NS-1:0]  s_d_valid;
  logic [NS-1:0]  s_d_ready;
  logic [NS*3-1:0]  s_d_opcode;
  logic [NS*3-1:0]  s_d_size;
  logic [NS*32-1:0] s_d_data;
  logic [NS-1:0]  s_d_denied;
  logic           busy;
  logic [7:0]     err_count;

  always #5 clk_24 = ~clk_24;

  tlul_xbar_1ton dut (
    .clk_24      (clk_24),
    .rst_n       (rst_n),
    .m_a_valid   (m_a_valid),
    .m_a_ready   (m_a_ready),
    .m_a_opcode  (m_a_opcode),
    .m_a_size    (m_a_size),
    .m_a_address (m_a_address),
    .m_a_mask    (m_a_mask),
    .m_a_data    (m_a_data),
    .m_d_valid   (m_d_valid),
    .m_d_ready   (m_d_ready),
    .m_d_opcode  (m_d_opcode),
    .m_d_size    (m_d_size),
    .m_d_data    (m_d_data),
    .m_d_denied  (m_d_denied),
    .s_a_valid   (s_a_valid),
    .s_a_ready   (s_a_ready),
    .s_a_opcode  (s_a_opcode),
    .s_a_size    (s_a_size),
    .s_a_address (s_a_address),
    .s_a_mask    (s_a_mask),
    .s_a_data    (s_a_data),
    .s_d_valid   (s_d_valid),
    .s_d_ready   (s_d_ready),
    .s_d_opcode  (s_d_opcode),
    .s_d_size    (s_d_size),
    .s_d_data    (s_d_data),
    .s_d_denied  (s_d_denied),
    .busy        (busy),
    .err_count   (err_count)
  );

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [31:0] data;
    logic        denied;
  } resp_t;

  resp_t sb_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [2:0] sz,
                          input logic [31:0] d, input logic den);
    resp_t r;
    r.opcode = op;
    r.size   = sz;
    r.data   = d;
    r.denied = den;
    sb_q.push_back(r);
  endtask

  task automatic slave_drive(input int idx, input logic v, input logic [2:0] op,
                             input logic [2:0] sz, input logic [31:0] d, input logic den);
    s_d_valid[idx]          = v;
    s_d_opcode[idx*3 +: 3]  = op;
    s_d_size[idx*3 +: 3]    = sz;
    s_d_data[idx*32 +: 32]  = d;
    s_d_denied[idx]         = den;
  endtask

  // Issue one A request; returns 1 ns after the accepting rising edge.
  task automatic send_a(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] d, input logic [3:0] mask, input logic [2:0] sz);
    @(negedge clk_24);
    m_a_valid   = 1'b1;
    m_a_opcode  = op;
    m_a_address = addr;
    m_a_data    = d;
    m_a_mask    = mask;
    m_a_size    = sz;
    #1;
    check("a_ready_idle", {63'd0, m_a_ready}, 64'd1);
    @(posedge clk_24);
    #1;
    m_a_valid = 1'b0;
  endtask

  // Wait (bounded) for a master D handshake and compare it with the
  // scoreboard head. exp_sdr is the expected s_d_ready at that moment.
  task automatic collect(input string tag, input int bound, input logic [NS-1:0] exp_sdr);
    logic  found;
    resp_t e;
    found = 1'b0;
    for (int c = 0; c < bound && !found; c++) begin
      @(negedge clk_24);
      m_d_ready = 1'b1;
      #1;
      if (m_d_valid) found = 1'b1;
    end
    check({tag, "_seen"}, {63'd0, found}, 64'd1);
    if (found) begin
      check({tag, "_sb_nonempty"}, {63'd0, (sb_q.size() != 0)}, 64'd1);
      check({tag, "_sdr"}, {60'd0, s_d_ready}, {60'd0, exp_sdr});
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check({tag, "_opcode"}, {61'd0, m_d_opcode}, {61'd0, e.opcode});
        check({tag, "_size"},   {61'd0, m_d_size},   {61'd0, e.size});
        check({tag, "_data"},   {32'd0, m_d_data},   {32'd0, e.data});
        check({tag, "_denied"}, {63'd0, m_d_denied}, {63'd0, e.denied});
      end
      @(posedge clk_24);
      #1;
    end
    m_d_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    m_a_valid   = 1'b0;
    m_a_opcode  = '0;
    m_a_size    = '0;
    m_a_address = '0;
    m_a_mask    = '0;
    m_a_data    = '0;
    m_d_ready   = 1'b0;
    s_a_ready   = '0;
    s_d_valid   = '0;
    s_d_opcode  = '0;
    s_d_size    = '0;
    s_d_data    = '0;
    s_d_denied  = '0;

    // ---- reset state ----
    #2;
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_m_d_valid", {63'd0, m_d_valid}, 64'd0);
    check("rst_s_a_valid", {60'd0, s_a_valid}, 64'd0);
    @(negedge clk_24);
    @(negedge clk_24);
    rst_n = 1'b1;
    #1;
    check("rel_m_a_ready", {63'd0, m_a_ready},   64'd1);
    check("rel_s_d_ready", {60'd0, s_d_ready},   64'd0);
    check("rel_err_count", {56'd0, err_count},   64'd0);
    check("rel_s_a_addr",  {32'd0, s_a_address}, 64'd0);

    // ---- Get to slave 1, slave ready immediately ----
    s_a_ready = 4'b0010;
    push_exp(3'd1, 3'd2, 32'hDEAD_BEEF, 1'b0);
    send_a(3'd4, 32'h0000_1004, 32'h0, 4'hF, 3'd2);
    @(negedge clk_24);
    #1;
    check("get1_s_a_valid", {60'd0, s_a_valid},   64'h2);
    check("get1_s_a_addr",  {32'd0, s_a_address}, 64'h1004);
    check("get1_busy",      {63'd0, busy},        64'd1);
    check("get1_m_a_ready", {63'd0, m_a_ready},   64'd0);
    slave_drive(1, 1'b1, 3'd1, 3'd2, 32'hDEAD_BEEF, 1'b0);
    collect("get1", 4, 4'b0010);
    slave_drive(1, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    s_a_ready = '0;
    check("get1_idle", {63'd0, busy}, 64'd0);

    // ---- PutFull to slave 3, s_a_ready delayed 5 cycles ----
    send_a(3'd0, 32'h0000_3000, 32'h1234_5678, 4'hF, 3'd2);
    m_a_address = 32'h0000_2000;
    m_a_data    = 32'hFFFF_FFFF;
    m_a_mask    = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_24);
      #1;
      check("put3_s_a_valid", {60'd0, s_a_valid},   64'h8);
      check("put3_s_a_addr",  {32'd0, s_a_address}, 64'h3000);
      check("put3_s_a_data",  {32'd0, s_a_data},    64'h1234_5678);
      check("put3_s_a_mask",  {60'd0, s_a_mask},    64'hF);
      check("put3_m_a_ready", {63'd0, m_a_ready},   64'd0);
      if (k == 4) s_a_ready = 4'b1000;
    end
    push_exp(3'd0, 3'd2, 32'h0, 1'b0);
    slave_drive(3, 1'b1, 3'd0, 3'd2, 32'h0, 1'b0);
    collect("put3", 4, 4'b1000);
    slave_drive(3, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    s_a_ready = '0;

    // ---- unmapped Get (field 16) and unmapped Put at field == NUM_SLAVES ----
    push_exp(3'd1, 3'd2, 32'h0, 1'b1);
    send_a(3'd4, 32'h0001_0000, 32'h0, 4'hF, 3'd2);
    @(negedge clk_24);
    #1;
    check("err_s_a_valid", {60'd0, s_a_valid}, 64'd0);
    check("err_m_d_valid", {63'd0, m_d_valid}, 64'd1);
    check("err_cnt1",      {56'd0, err_count}, CNT_EN ? 64'd1 : 64'd0);
    collect("err_get", 4, 4'b0000);
    push_exp(3'd0, 3'd0, 32'h0, 1'b1);
    send_a(3'd1, 32'h0000_4000, 32'h5A5A_5A5A, 4'h1, 3'd0);
    collect("err_put", 4, 4'b0000);
    check("err_cnt2", {56'd0, err_count}, CNT_EN ? 64'd2 : 64'd0);

    // ---- slave 2 target, slave 0 and early slave 2 responses ignored ----
    push_exp(3'd1, 3'd2, 32'hCAFE_0002, 1'b0);
    send_a(3'd4, 32'h0000_2008, 32'h0, 4'hF, 3'd2);
    @(negedge clk_24);
    slave_drive(0, 1'b1, 3'd1, 3'd2, 32'h1111_1111, 1'b0);
    slave_drive(2, 1'b1, 3'd1, 3'd2, 32'hCAFE_0002, 1'b0);
    m_d_ready = 1'b1;
    #1;
    check("s2_req_m_d_valid", {63'd0, m_d_valid}, 64'd0);
    check("s2_req_s_d_ready", {60'd0, s_d_ready}, 64'd0);
    check("s2_req_s_a_valid", {60'd0, s_a_valid}, 64'h4);
    m_d_ready = 1'b0;
    slave_drive(2, 1'b0, 3'd1, 3'd2, 32'hCAFE_0002, 1'b0);
    s_a_ready = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_24);
      #1;
      check("s2_wait_m_d_valid", {63'd0, m_d_valid}, 64'd0);
      check("s2_wait_s_d_ready", {60'd0, s_d_ready}, 64'd0);
    end
    slave_drive(2, 1'b1, 3'd1, 3'd2, 32'hCAFE_0002, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_24);
      #1;
      check("s2_hold_m_d_valid", {63'd0, m_d_valid}, 64'd1);
      check("s2_hold_m_d_data",  {32'd0, m_d_data},  64'hCAFE_0002);
      check("s2_hold_s_d_ready", {60'd0, s_d_ready}, 64'd0);
    end
    collect("s2", 4, 4'b0100);
    slave_drive(0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    slave_drive(2, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    s_a_ready = '0;

    // ---- reset asserted in RESP, then a normal Get to slave 0 ----
    s_a_ready = 4'b0001;
    send_a(3'd4, 32'h0000_0010, 32'h0, 4'hF, 3'd2);
    @(negedge clk_24);
    #1;
    check("rr_s_a_valid", {60'd0, s_a_valid}, 64'h1);
    @(negedge clk_24);
    slave_drive(0, 1'b1, 3'd1, 3'd2, 32'h5555_AAAA, 1'b0);
    m_d_ready = 1'b1;
    #1;
    check("rr_pre_m_d_valid", {63'd0, m_d_valid}, 64'd1);
    check("rr_pre_s_d_ready", {60'd0, s_d_ready}, 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rr_m_d_valid", {63'd0, m_d_valid},   64'd0);
    check("rr_s_d_ready", {60'd0, s_d_ready},   64'd0);
    check("rr_busy",      {63'd0, busy},        64'd0);
    check("rr_s_a_valid", {60'd0, s_a_valid},   64'd0);
    check("rr_s_a_addr",  {32'd0, s_a_address}, 64'd0);
    check("rr_err_count", {56'd0, err_count},   64'd0);
    @(negedge clk_24);
    rst_n     = 1'b1;
    m_d_ready = 1'b0;
    slave_drive(0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    #1;
    check("rr_rel_m_a_ready", {63'd0, m_a_ready}, 64'd1);
    push_exp(3'd1, 3'd2, 32'h0BAD_F00D, 1'b0);
    send_a(3'd4, 32'h0000_0020, 32'h0, 4'hF, 3'd2);
    slave_drive(0, 1'b1, 3'd1, 3'd2, 32'h0BAD_F00D, 1'b0);
    collect("get0", 5, 4'b0001);
    slave_drive(0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
    s_a_ready = '0;

    // ---- 300 unmapped requests: counter saturates at 255 ----
    for (int k = 0; k < 300; k++) begin
      push_exp(3'd1, 3'd2, 32'h0, 1'b1);
      send_a(3'd4, 32'h8000_0000 | 32'(k), 32'h0, 4'hF, 3'd2);
      collect("err_loop", 4, 4'b0000);
      if (k == 254) check("err_cnt_255", {56'd0, err_count}, CNT_EN ? 64'd255 : 64'd0);
    end
    check("err_cnt_sat", {56'd0, err_count}, CNT_EN ? 64'd255 : 64'd0);

    check("sb_drained", {32'd0, sb_q.size()}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
